// File: rtl/rom_scan_pkg.sv
// Shared types and constants for the ROM scan/fill Avalon-MM master.
package rom_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_SCAN = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/rom_scan_lat_pipe.sv
// Read-latency valid tracker: one bit enters per accepted read and leaves
// DEPTH cycles later, marking the cycle in which the slave's data is valid.
module rom_scan_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  output logic pop,
  output logic empty,
  output logic drain_ok
);

  // All stages except the oldest; zero for a single-stage pipe.
  localparam logic [DEPTH-1:0] LOW_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] push_vec_s;

  // Place the new entry in stage 0 only.
  always_comb begin
    push_vec_s    = '0;
    push_vec_s[0] = push;
  end

  // Shift the valid bits one stage per cycle; reset discards in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
    end else begin
      valid_r <= (valid_r << 1) | push_vec_s;
    end
  end

  assign pop      = valid_r[DEPTH-1];
  assign empty    = (valid_r == '0);
  // True when the pipe will be empty after this cycle's pop.
  assign drain_ok = ((valid_r & LOW_MASK) == '0) && !push;

endmodule

// File: rtl/rom_scan_master.sv
// Avalon-MM master that walks a word range of a slave, either reading it and
// summing the data (scan) or writing a constant word into it (fill).
module rom_scan_master
  import rom_scan_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [DATA_W-1:0]   fill_data,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_debugaccess,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  state_t              state_r;
  state_t              state_s;
  logic                arm_r;
  logic                mode_r;
  logic [DATA_W-1:0]   fill_r;
  logic [ADDR_W:0]     remain_r;

  logic                start_ok_s;
  logic                accept_s;
  logic                last_s;
  logic                push_s;
  logic                pipe_pop_s;
  logic                pipe_empty_s;
  logic                pipe_drain_ok_s;

  assign start_ok_s = start && arm_r && (state_r == ST_IDLE);
  assign accept_s   = avm_chipselect && !avm_waitrequest;
  assign last_s     = accept_s && (remain_r == (ADDR_W+1)'(1));
  assign push_s     = accept_s && avm_read;

  rom_scan_lat_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_lat_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .pop      (pipe_pop_s),
    .empty    (pipe_empty_s),
    .drain_ok (pipe_drain_ok_s)
  );

  // Start is only honoured after one clock edge following reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_r <= 1'b0;
    end else begin
      arm_r <= 1'b1;
    end
  end

  // Next-state decode for the job sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if (word_count == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          if (mode_r == MODE_FILL) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_s || pipe_drain_ok_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != ST_IDLE);
      done    <= (state_s == ST_DONE);
    end
  end

  // Job parameters and the bus command; the command only moves on acceptance,
  // so everything holds while the slave stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r          <= MODE_SCAN;
      fill_r          <= '0;
      remain_r        <= '0;
      avm_address     <= '0;
      avm_chipselect  <= 1'b0;
      avm_read        <= 1'b0;
      avm_write       <= 1'b0;
      avm_writedata   <= '0;
      avm_byteenable  <= '0;
      avm_debugaccess <= 1'b0;
    end else if (start_ok_s) begin
      mode_r      <= mode;
      fill_r      <= fill_data;
      remain_r    <= word_count;
      avm_address <= base_addr;
      if (word_count != '0) begin
        avm_chipselect  <= 1'b1;
        avm_read        <= (mode == MODE_SCAN);
        avm_write       <= (mode == MODE_FILL);
        avm_writedata   <= (mode == MODE_FILL) ? fill_data : '0;
        avm_byteenable  <= '1;
        avm_debugaccess <= (mode == MODE_FILL);
      end
    end else if (accept_s) begin
      remain_r <= remain_r - (ADDR_W+1)'(1);
      if (last_s) begin
        avm_address     <= '0;
        avm_chipselect  <= 1'b0;
        avm_read        <= 1'b0;
        avm_write       <= 1'b0;
        avm_writedata   <= '0;
        avm_byteenable  <= '0;
        avm_debugaccess <= 1'b0;
      end else begin
        avm_address <= avm_address + ADDR_W'(1);
      end
    end
  end

  // Checksum: cleared on start, fill words added on acceptance, read data
  // added when the latency pipe says it is valid; carry is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (start_ok_s) begin
      checksum <= '0;
    end else if (accept_s && avm_write) begin
      checksum <= checksum + fill_r;
    end else if (pipe_pop_s) begin
      checksum <= checksum + avm_readdata;
    end
  end

endmodule
